// File: rtl/regs_wb_ctrl_pkg.sv
// rtl/regs_wb_ctrl_pkg.sv - shared register-file constants and writeback types
package regs_wb_ctrl_pkg;

  localparam int          REG_ADDR_W    = 5;
  localparam int          REG_DATA_W    = 32;
  localparam int          REG_NUM       = 32;
  localparam logic        RST_ENABLE    = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_FIFO,
    SRC_LU
  } wb_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_DATA_W-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/regs_wb_ctrl_wb_fifo.sv
// rtl/regs_wb_ctrl_wb_fifo.sv - synchronous FIFO buffering long-latency writeback entries
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  // Pointers carry one bit beyond the index so full and empty differ.
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  generate
    if (DEPTH > 1) begin : g_idx
      assign wr_idx = wr_ptr[IW-1:0];
      assign rd_idx = rd_ptr[IW-1:0];
    end else begin : g_idx_one
      assign wr_idx = '0;
      assign rd_idx = '0;
    end
  endgenerate

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_idx == rd_idx);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/regs_wb_ctrl.sv
// rtl/regs_wb_ctrl.sv - register-file write port arbiter with long-latency scoreboard
module regs_wb_ctrl
  import regs_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_waddr_i,
  input  logic [31:0] lu_wdata_i,
  output logic        lu_ready_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_waddr_i,
  input  logic [4:0]  chk_raddr1_i,
  input  logic [4:0]  chk_raddr2_i,
  input  logic [4:0]  chk_waddr_i,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic [31:0] busy_o,
  output logic        stall_o
);

  wb_src_e               src;
  wb_entry_t             head;
  wb_entry_t             lu_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  lu_xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [REG_DATA_W-1:0] sel_data;
  logic [REG_NUM-1:0]    busy_q;
  logic [REG_NUM-1:0]    busy_d;
  logic                  in_reset;

  assign in_reset   = (rst == RST_ENABLE);
  assign lu_ready_o = !fifo_full;
  assign lu_xfer    = lu_valid_i && lu_ready_o;
  assign lu_entry   = '{waddr: lu_waddr_i, wdata: lu_wdata_i};

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REG_ADDR_W + REG_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (lu_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pipe retire always wins; a buffered head drains before any new lu result bypasses.
  always_comb begin
    src       = SRC_NONE;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (pipe_we_i) begin
      src       = SRC_PIPE;
      fifo_push = lu_xfer;
    end else if (!fifo_empty) begin
      src       = SRC_FIFO;
      fifo_pop  = 1'b1;
      fifo_push = lu_xfer;
    end else if (lu_xfer) begin
      src       = SRC_LU;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = ZERO_WORD;
    case (src)
      SRC_PIPE: begin
        sel_addr = pipe_waddr_i;
        sel_data = pipe_wdata_i;
      end
      SRC_FIFO: begin
        sel_addr = head.waddr;
        sel_data = head.wdata;
      end
      SRC_LU: begin
        sel_addr = lu_waddr_i;
        sel_data = lu_wdata_i;
      end
      default: begin
        sel_addr = '0;
        sel_data = ZERO_WORD;
      end
    endcase
  end

  // Outputs are gated by reset so the write port goes quiet the moment rst falls.
  always_comb begin
    we_o    = WRITE_DISABLE;
    waddr_o = '0;
    wdata_o = ZERO_WORD;
    if (!in_reset) begin
      waddr_o = sel_addr;
      wdata_o = sel_data;
      if (src != SRC_NONE && sel_addr != '0) we_o = WRITE_ENABLE;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit pending.
  always_comb begin
    busy_d = busy_q;
    if (src == SRC_FIFO || src == SRC_LU) busy_d[sel_addr] = 1'b0;
    if (issue_i && issue_waddr_i != '0) busy_d[issue_waddr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_o  = busy_q;
  assign stall_o = busy_q[chk_raddr1_i] | busy_q[chk_raddr2_i] | busy_q[chk_waddr_i];

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// tb/tb_regs_wb_ctrl.sv - table-driven self-checking bench with lu writeback scoreboard
module tb_regs_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we_i;
  logic [4:0]  pipe_waddr_i;
  logic [31:0] pipe_wdata_i;
  logic        lu_valid_i;
  logic [4:0]  lu_waddr_i;
  logic [31:0] lu_wdata_i;
  logic        lu_ready_o;
  logic        issue_i;
  logic [4:0]  issue_waddr_i;
  logic [4:0]  chk_raddr1_i;
  logic [4:0]  chk_raddr2_i;
  logic [4:0]  chk_waddr_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [31:0] busy_o;
  logic        stall_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic [4:0]  cw;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic        erdy;
    logic        estall;
    logic [31:0] ebusy;
  } vec_t;

  logic [36:0] sb_q [$];
  vec_t        vt [26];

  regs_wb_ctrl #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_we_i     (pipe_we_i),
    .pipe_waddr_i  (pipe_waddr_i),
    .pipe_wdata_i  (pipe_wdata_i),
    .lu_valid_i    (lu_valid_i),
    .lu_waddr_i    (lu_waddr_i),
    .lu_wdata_i    (lu_wdata_i),
    .lu_ready_o    (lu_ready_o),
    .issue_i       (issue_i),
    .issue_waddr_i (issue_waddr_i),
    .chk_raddr1_i  (chk_raddr1_i),
    .chk_raddr2_i  (chk_raddr2_i),
    .chk_waddr_i   (chk_waddr_i),
    .we_o          (we_o),
    .waddr_o       (waddr_o),
    .wdata_o       (wdata_o),
    .busy_o        (busy_o),
    .stall_o       (stall_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic pwe, logic [4:0] pa, logic [31:0] pd,
                              logic lv, logic [4:0] la, logic [31:0] ld,
                              logic iss, logic [4:0] ia,
                              logic [4:0] c1, logic [4:0] c2, logic [4:0] cw,
                              logic ewe, logic [4:0] ewa, logic [31:0] ewd,
                              logic erdy, logic estall, logic [31:0] ebusy);
    vec_t v;
    v.pwe = pwe; v.pa = pa; v.pd = pd;
    v.lv = lv; v.la = la; v.ld = ld;
    v.iss = iss; v.ia = ia;
    v.c1 = c1; v.c2 = c2; v.cw = cw;
    v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
    v.erdy = erdy; v.estall = estall; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pipe_we_i     = v.pwe;
    pipe_waddr_i  = v.pa;
    pipe_wdata_i  = v.pd;
    lu_valid_i    = v.lv;
    lu_waddr_i    = v.la;
    lu_wdata_i    = v.ld;
    issue_i       = v.iss;
    issue_waddr_i = v.ia;
    chk_raddr1_i  = v.c1;
    chk_raddr2_i  = v.c2;
    chk_waddr_i   = v.cw;
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [36:0] got;
    logic [36:0] exp;
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    chk({tag, "_we"}, {31'd0, we_o}, {31'd0, v.ewe});
    if (v.ewe) begin
      chk({tag, "_waddr"}, {27'd0, waddr_o}, {27'd0, v.ewa});
      chk({tag, "_wdata"}, wdata_o, v.ewd);
    end
    chk({tag, "_ready"}, {31'd0, lu_ready_o}, {31'd0, v.erdy});
    chk({tag, "_stall"}, {31'd0, stall_o}, {31'd0, v.estall});
    chk({tag, "_busy"}, busy_o, v.ebusy);
    if (v.lv && lu_ready_o && v.la != 5'd0) sb_q.push_back({v.la, v.ld});
    if (we_o && !v.pwe) begin
      got = {waddr_o, wdata_o};
      if (sb_q.size() == 0) begin
        chk({tag, "_sb_unexpected"}, {27'd0, waddr_o}, 32'hffff_ffff);
      end else begin
        exp = sb_q.pop_front();
        chk({tag, "_sb_addr"}, {27'd0, got[36:32]}, {27'd0, exp[36:32]});
        chk({tag, "_sb_data"}, got[31:0], exp[31:0]);
      end
    end
  endtask

  vec_t idle;

  initial begin
    rst = 1'b0;
    idle = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 1,0,0);
    drive(idle);
    chk_raddr1_i = 5'd5;
    #12;
    chk("rst_we", {31'd0, we_o}, 32'd0);
    chk("rst_waddr", {27'd0, waddr_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_ready", {31'd0, lu_ready_o}, 32'd1);
    chk("rst_busy", busy_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    #20;
    rst = 1'b1;

    //                pwe pa pd      lv la  ld          iss ia  c1 c2 cw  ewe ewa ewd        rdy stl busy
    vt[0]  = mk(0,0,0,          0,0,0,              0,0,  0,0,0,   0,0,0,              1,0,32'h0);
    vt[1]  = mk(0,0,0,          0,0,0,              1,5,  0,0,0,   0,0,0,              1,0,32'h0);
    vt[2]  = mk(0,0,0,          1,5,32'h1234,       0,0,  0,0,0,   1,5,32'h1234,       1,0,32'h20);
    vt[3]  = mk(0,0,0,          0,0,0,              0,0,  5,0,0,   0,0,0,              1,0,32'h0);
    vt[4]  = mk(1,3,32'hA,      1,7,32'hB,          1,7,  0,0,0,   1,3,32'hA,          1,0,32'h0);
    vt[5]  = mk(0,0,0,          0,0,0,              0,0,  7,0,0,   1,7,32'hB,          1,1,32'h80);
    vt[6]  = mk(0,0,0,          0,0,0,              0,0,  7,0,0,   0,0,0,              1,0,32'h0);
    vt[7]  = mk(1,1,32'h11,     1,8,32'h88,         0,0,  0,0,0,   1,1,32'h11,         1,0,32'h0);
    vt[8]  = mk(1,1,32'h12,     1,9,32'h99,         0,0,  0,0,0,   1,1,32'h12,         1,0,32'h0);
    vt[9]  = mk(1,1,32'h13,     1,10,32'hAA,        0,0,  0,0,0,   1,1,32'h13,         0,0,32'h0);
    vt[10] = mk(1,1,32'h14,     1,10,32'hAA,        0,0,  0,0,0,   1,1,32'h14,         0,0,32'h0);
    vt[11] = mk(0,0,0,          1,10,32'hAA,        0,0,  0,0,0,   1,8,32'h88,         0,0,32'h0);
    vt[12] = mk(0,0,0,          1,10,32'hAA,        0,0,  0,0,0,   1,9,32'h99,         1,0,32'h0);
    vt[13] = mk(0,0,0,          0,0,0,              0,0,  0,0,0,   1,10,32'hAA,        1,0,32'h0);
    vt[14] = mk(0,0,0,          0,0,0,              0,0,  0,0,0,   0,0,0,              1,0,32'h0);
    vt[15] = mk(0,0,0,          0,0,0,              1,12, 12,0,0,  0,0,0,              1,0,32'h0);
    vt[16] = mk(0,0,0,          0,0,0,              0,0,  12,0,0,  0,0,0,              1,1,32'h1000);
    vt[17] = mk(0,0,0,          0,0,0,              0,0,  0,0,0,   0,0,0,              1,0,32'h1000);
    vt[18] = mk(0,0,0,          0,0,0,              0,0,  0,0,12,  0,0,0,              1,1,32'h1000);
    vt[19] = mk(0,0,0,          1,12,32'hC,         0,0,  12,0,0,  1,12,32'hC,         1,1,32'h1000);
    vt[20] = mk(0,0,0,          0,0,0,              0,0,  12,0,0,  0,0,0,              1,0,32'h0);
    vt[21] = mk(0,0,0,          0,0,0,              1,4,  0,0,0,   0,0,0,              1,0,32'h0);
    vt[22] = mk(0,0,0,          1,4,32'h44,         1,4,  0,0,0,   1,4,32'h44,         1,0,32'h10);
    vt[23] = mk(0,0,0,          1,0,32'h55,         0,0,  0,4,0,   0,0,0,              1,1,32'h10);
    vt[24] = mk(0,0,0,          1,4,32'h45,         0,0,  0,0,0,   1,4,32'h45,         1,0,32'h10);
    vt[25] = mk(0,0,0,          0,0,0,              0,0,  0,4,0,   0,0,0,              1,0,32'h0);

    for (int i = 0; i < 26; i++) apply(vt[i], $sformatf("v%0d", i));
    chk("sb_drained", sb_q.size(), 32'd0);

    // Reset mid-stream with two buffered entries and two pending registers.
    apply(mk(0,0,0,      0,0,0,           1,20, 0,0,0, 0,0,0,          1,0,32'h0),      "r0");
    apply(mk(0,0,0,      0,0,0,           1,21, 0,0,0, 0,0,0,          1,0,32'h100000), "r1");
    apply(mk(1,2,32'h22, 1,20,32'h2020,   0,0,  0,0,0, 1,2,32'h22,     1,0,32'h300000), "r2");
    apply(mk(1,2,32'h23, 1,21,32'h2121,   0,0,  0,0,0, 1,2,32'h23,     1,0,32'h300000), "r3");
    @(posedge clk);
    #1;
    drive(idle);
    chk_raddr1_i = 5'd20;
    #1;
    chk("pre_rst_we", {31'd0, we_o}, 32'd1);
    chk("pre_rst_waddr", {27'd0, waddr_o}, 32'd20);
    chk("pre_rst_ready", {31'd0, lu_ready_o}, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, we_o}, 32'd0);
    chk("mid_rst_waddr", {27'd0, waddr_o}, 32'd0);
    chk("mid_rst_wdata", wdata_o, 32'd0);
    chk("mid_rst_busy", busy_o, 32'd0);
    chk("mid_rst_ready", {31'd0, lu_ready_o}, 32'd1);
    chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      apply(mk(0,0,0, 0,0,0, 0,0, 20,21,0, 0,0,0, 1,0,32'h0), $sformatf("post%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regs_wb_ctrl.md
# regs_wb_ctrl

Writeback controller on the producer side of the register file's single write port. It merges two result sources onto that port. The single-cycle pipeline retire path always has priority. Long-latency results (divider, load unit) arrive through a valid/ready handshake and are buffered in a small FIFO. A 32-bit busy scoreboard tracks registers with an outstanding long-latency result, and the block raises a hazard stall toward decode.

## Interface
- DEPTH, 2, long-latency result FIFO entries (≥1, power of two).
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (`RstEnable` = 0).
- pipe_we_i  in  1  pipeline retire write request; never back-pressured.
- pipe_waddr_i  in  5  pipeline destination register.
- pipe_wdata_i  in  32  pipeline result.
- lu_valid_i  in  1  long-latency result valid.
- lu_waddr_i  in  5  long-latency destination register.
- lu_wdata_i  in  32  long-latency result.
- lu_ready_o  out  1  FIFO can accept; reset value 1.
- issue_i  in  1  long-latency op issued this cycle.
- issue_waddr_i  in  5  its destination register.
- chk_raddr1_i, chk_raddr2_i, chk_waddr_i  in  5 each  decode-stage operand and destination addresses for hazard check.
- we_o  out  1  register file write enable; reset value 0.
- waddr_o  out  5  register file write address; reset value 0.
- wdata_o  out  32  register file write data; reset value 0.
- busy_o  out  32  scoreboard, bit n = xn pending; reset value 0.
- stall_o  out  1  hazard stall; reset value 0.

## Operation
- Handshake: a result is accepted when lu_valid_i && lu_ready_o. lu_ready_o = !full. It does not account for a same-cycle pop.
- Write-port arbitration, evaluated each cycle, first match wins:
  1. pipe_we_i: drive the pipe address and data.
  2. FIFO non-empty: drive the head entry and pop it.
  3. FIFO empty and an lu transfer occurs: pass the result straight through; it is not enqueued.
  4. Otherwise we_o = 0.
- An lu transfer that is not passed through is pushed to the FIFO tail. A push and a pop in the same cycle are both legal.
- Results to x0 are accepted and consumed normally, but force we_o = 0.
- Scoreboard set: issue_i with issue_waddr_i ≠ 0 sets busy[issue_waddr_i].
- Scoreboard clear: an lu-sourced write (pop or pass-through) clears busy[waddr].
- Set and clear of the same bit in the same cycle: set wins.
- Pipe writes never touch the scoreboard.
- stall_o = busy[chk_raddr1_i] | busy[chk_raddr2_i] | busy[chk_waddr_i]. Address 0 is never busy. The chk_waddr_i term blocks WAW, so a pipe write to a busy register cannot occur in a correct pipeline.
- Reset mid-operation, effective asynchronously:
  - FIFO emptied, in-flight results discarded.
  - busy_o cleared.
  - Write-port outputs forced to 0.

## Timing
- we_o, waddr_o, wdata_o, stall_o and lu_ready_o are combinational from inputs and registered state, with no added cycle.
- The register file's write-to-read bypass therefore sees a write in the same cycle.
- Pass-through latency: 0 cycles from lu transfer to we_o.
- Buffered latency: at least 1 cycle. Each consecutive pipe_we_i cycle adds one cycle.
- busy_o and FIFO occupancy update on the rising edge after the causing event.
- A register issued in cycle t reads busy from t+1. It clears at the edge after its lu write.
- FIFO full: lu_ready_o = 0 for the whole cycle, even if a pop happens; ready returns the next cycle.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.

## Structure
- Register address/data widths, `RegNum`, `RstEnable`, `WriteEnable`/`WriteDisable` and `ZeroWord` come from yadan_defs.v.
- No new shared constants are introduced; DEPTH stays local.
- One sub-module: wb_fifo. It is a parameterised synchronous FIFO of {waddr, wdata}, 37 bits wide, with push/pop/full/empty.
- Arbitration and scoreboard stay in regs_wb_ctrl.

## Test plan
- Pass-through: FIFO empty, pipe idle, lu x5 = 0x1234 with issue x5 earlier → we_o=1, waddr_o=5, wdata_o=0x1234 in the same cycle; busy_o[5] 1→0 next edge.
- Priority: pipe x3 = 0xA and lu x7 = 0xB in the same cycle → x3 written; x7 enqueued; x7 written the following cycle.
- Full and back-pressure (DEPTH=2): hold pipe_we_i for 4 cycles while lu offers x8, x9, x10 → lu_ready_o falls after 2 pushes. After the pipe stops, x8 then x9 are written in order, then x10 is accepted.
- Hazard: issue x12; decode checks raddr1=12 → stall_o=1 until the x12 lu write. A check with raddr=0 never stalls.
- Same-cycle set/clear: lu writes x4 while issue x4 → busy_o[4] remains 1. An lu result to x0 → we_o=0, accepted.
- Reset mid-stream: assert rst with 2 FIFO entries and busy bits set → we_o=0 immediately. After release: busy_o=0, lu_ready_o=1, and no stale writes.
